result_reader: RTL and testbench

RESULT_READER -- requirements
Module: result_reader

---
 rtl/result_reader_pkg.sv | 21 ++
 rtl/result_fifo.sv | 55 +++++
 rtl/result_reader.sv | 215 +++++++++++++++++++++
 tb/tb_result_reader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_reader_pkg.sv
// Shared definitions for the result reader.
// Holds the readout FSM state encoding and the word offsets of the result
// header relative to the result base address.
package result_reader_pkg;

  // Offsets of the header words and the first element from the base address
  localparam int ROWS_OFS = 0;
  localparam int COLS_OFS = 1;
  localparam int DATA_OFS = 2;

  // Readout FSM state encoding
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_RD_ROWS = 3'd1;
  localparam logic [STATE_W-1:0] S_RD_COLS = 3'd2;
  localparam logic [STATE_W-1:0] S_CHECK   = 3'd3;
  localparam logic [STATE_W-1:0] S_STREAM  = 3'd4;
  localparam logic [STATE_W-1:0] S_DRAIN   = 3'd5;
  localparam logic [STATE_W-1:0] S_FINISH  = 3'd6;

endpackage

// File: rtl/result_fifo.sv
// Two-entry FIFO holding result elements together with their row/column tag
// and last marker until the stream consumer accepts them.
// Ports:
//   clk, reset  - clock and synchronous active-high reset (flushes contents)
//   i_push      - write i_data this cycle (caller never pushes when full)
//   i_data      - payload to store
//   i_pop       - discard the head entry this cycle (caller only pops when valid)
//   o_data      - head entry payload
//   o_valid     - FIFO holds at least one entry
//   o_count     - number of stored entries (0..2)
module result_fifo #(
  parameter int WIDTH = 47
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wrPtr;
  logic             r_rdPtr;
  logic [1:0]       r_count;

  // Pointers and occupancy; push and pop may happen in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_wrPtr <= ~r_wrPtr;
      if (i_pop)  r_rdPtr <= ~r_rdPtr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once counted
  always_ff @(posedge clk) begin
    if (i_push && !reset) r_mem[r_wrPtr] <= i_data;
  end

  assign o_data  = r_mem[r_rdPtr];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/result_reader.sv
// Reads a matrix result out of the multiplier's memory and streams it out
// element by element with row/column tags.
// Ports:
//   clk, reset       - clock and synchronous active-high reset
//   result_ready     - multiplier done level; a rising edge starts a readout
//   memory_data_out  - read data, valid one cycle after memory_address
//   memory_address   - read address
//   write_enable     - always 0, the block only reads
//   out_data/out_row/out_col/out_last - element, its indices, final marker
//   out_valid/out_ready - stream handshake
//   busy             - readout in progress
//   done             - one-cycle completion pulse (also after a bad header)
//   error            - sticky bad-dimension flag, cleared by the next start
module result_reader
  import result_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int MAX_LEN     = 100,
  parameter int MAX_LEN_LOG = 7,
  parameter int RES_BASE    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   result_ready,
  input  logic [DATA_WIDTH-1:0]  memory_data_out,
  output logic [ADDR_WIDTH-1:0]  memory_address,
  output logic                   write_enable,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [MAX_LEN_LOG-1:0] out_row,
  output logic [MAX_LEN_LOG-1:0] out_col,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int PAYLOAD_W = DATA_WIDTH + 2*MAX_LEN_LOG + 1;

  // Address constants wrap at ADDR_WIDTH bits so a base near the top of
  // memory rolls over to address 0
  localparam logic [ADDR_WIDTH-1:0]  ROWS_ADDR = ADDR_WIDTH'(RES_BASE + ROWS_OFS);
  localparam logic [ADDR_WIDTH-1:0]  COLS_ADDR = ADDR_WIDTH'(RES_BASE + COLS_OFS);
  localparam logic [ADDR_WIDTH-1:0]  DATA_ADDR = ADDR_WIDTH'(RES_BASE + DATA_OFS);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [MAX_LEN_LOG-1:0] IDX_ONE   = MAX_LEN_LOG'(1);
  localparam logic [DATA_WIDTH-1:0]  MAX_LEN_W = DATA_WIDTH'(MAX_LEN);

  logic [STATE_W-1:0]     r_state;
  logic                   r_rrPrev;
  logic                   r_error;
  logic [DATA_WIDTH-1:0]  r_rows;
  logic [MAX_LEN_LOG-1:0] r_cols;
  logic [MAX_LEN_LOG-1:0] r_rowCnt;
  logic [MAX_LEN_LOG-1:0] r_colCnt;
  logic [ADDR_WIDTH-1:0]  r_elemAddr;
  logic                   r_inFlight;
  logic [MAX_LEN_LOG-1:0] r_pendRow;
  logic [MAX_LEN_LOG-1:0] r_pendCol;
  logic                   r_pendLast;

  logic                   w_start;
  logic                   w_bad;
  logic                   w_colWrap;
  logic                   w_lastIssue;
  logic                   w_issue;
  logic                   w_pop;
  logic                   w_outValid;
  logic [2:0]             w_occ;
  logic [2:0]             w_limit;
  logic                   w_fifoValid;
  logic [1:0]             w_fifoCount;
  logic [PAYLOAD_W-1:0]   w_pushData;
  logic [PAYLOAD_W-1:0]   w_head;
  logic [DATA_WIDTH-1:0]  w_headData;
  logic [MAX_LEN_LOG-1:0] w_headRow;
  logic [MAX_LEN_LOG-1:0] w_headCol;
  logic                   w_headLast;
  logic [ADDR_WIDTH-1:0]  w_addr;

  // Only a 0->1 transition of result_ready starts a readout, and only from IDLE
  assign w_start = result_ready && !r_rrPrev && (r_state == S_IDLE);

  // Header check in CHECK: R is registered, C is the word arriving now;
  // full-width compares so large header words cannot alias into range
  assign w_bad = (r_rows == '0) || (r_rows > MAX_LEN_W) ||
                 (memory_data_out == '0) || (memory_data_out > MAX_LEN_W);

  assign w_colWrap   = (r_colCnt == r_cols - IDX_ONE);
  assign w_lastIssue = w_colWrap && (r_rowCnt == r_rows[MAX_LEN_LOG-1:0] - IDX_ONE);

  // Credit check counts a pop this cycle as free space, which keeps one read
  // per cycle flowing while the consumer accepts every cycle
  assign w_outValid = w_fifoValid && !reset;
  assign w_pop      = w_outValid && out_ready;
  assign w_occ      = {1'b0, w_fifoCount} + {2'b00, r_inFlight};
  assign w_limit    = 3'd2 + {2'b00, w_pop};
  assign w_issue    = (r_state == S_STREAM) && (w_occ < w_limit);

  assign w_pushData = {memory_data_out, r_pendRow, r_pendCol, r_pendLast};

  result_fifo #(
    .WIDTH(PAYLOAD_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inFlight),
    .i_data  (w_pushData),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_fifoValid),
    .o_count (w_fifoCount)
  );

  assign w_headLast = w_head[0];
  assign w_headCol  = w_head[MAX_LEN_LOG:1];
  assign w_headRow  = w_head[2*MAX_LEN_LOG:MAX_LEN_LOG+1];
  assign w_headData = w_head[PAYLOAD_W-1:2*MAX_LEN_LOG+1];

  // Readout sequencing; tags of an issued read travel alongside it for one
  // cycle so the returned word enters the FIFO already labelled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rrPrev   <= result_ready;
      r_error    <= 1'b0;
      r_rows     <= '0;
      r_cols     <= '0;
      r_rowCnt   <= '0;
      r_colCnt   <= '0;
      r_elemAddr <= '0;
      r_inFlight <= 1'b0;
      r_pendRow  <= '0;
      r_pendCol  <= '0;
      r_pendLast <= 1'b0;
    end else begin
      r_rrPrev   <= result_ready;
      r_inFlight <= w_issue;
      if (w_issue) begin
        r_pendRow  <= r_rowCnt;
        r_pendCol  <= r_colCnt;
        r_pendLast <= w_lastIssue;
      end
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_RD_ROWS;
            r_error    <= 1'b0;
            r_rowCnt   <= '0;
            r_colCnt   <= '0;
            r_elemAddr <= DATA_ADDR;
          end
        end
        S_RD_ROWS: r_state <= S_RD_COLS;
        S_RD_COLS: begin
          r_rows  <= memory_data_out;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_cols <= memory_data_out[MAX_LEN_LOG-1:0];
          if (w_bad) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_issue) begin
            r_elemAddr <= r_elemAddr + ADDR_ONE;
            if (w_colWrap) begin
              r_colCnt <= '0;
              r_rowCnt <= r_rowCnt + IDX_ONE;
            end else begin
              r_colCnt <= r_colCnt + IDX_ONE;
            end
            if (w_lastIssue) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && w_headLast) r_state <= S_FINISH;
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Read address by state; element addresses come from a running pointer
  always_comb begin
    w_addr = '0;
    case (r_state)
      S_RD_ROWS: w_addr = ROWS_ADDR;
      S_RD_COLS: w_addr = COLS_ADDR;
      S_STREAM:  w_addr = r_elemAddr;
      default:   w_addr = '0;
    endcase
  end

  // Outputs are forced low while reset is asserted so an abort is visible
  // in the same cycle, and stream fields read zero whenever nothing is offered
  assign memory_address = reset ? '0 : w_addr;
  assign write_enable   = 1'b0;
  assign out_valid      = w_outValid;
  assign out_data       = w_outValid ? w_headData : '0;
  assign out_row        = w_outValid ? w_headRow  : '0;
  assign out_col        = w_outValid ? w_headCol  : '0;
  assign out_last       = w_outValid && w_headLast;
  assign busy           = !reset && (r_state != S_IDLE);
  assign done           = !reset && ((r_state == S_FINISH) || ((r_state == S_CHECK) && w_bad));
  assign error          = !reset && r_error;

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: memory model with one-cycle read latency,
// expected elements queued when a readout is launched and consumed by an
// independent stream monitor.
module tb_result_reader;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int ML    = 100;
  localparam int MLL   = 7;
  localparam int BASE  = 4094;
  localparam int MEMSZ = 4096;

  logic           clk = 1'b0;
  logic           reset;
  logic           result_ready;
  logic [DW-1:0]  memory_data_out;
  logic [AW-1:0]  memory_address;
  logic           write_enable;
  logic [DW-1:0]  out_data;
  logic [MLL-1:0] out_row;
  logic [MLL-1:0] out_col;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic           busy;
  logic           done;
  logic           error;

  typedef struct {
    logic [31:0] data;
    int          row;
    int          col;
    logic        last;
  } expItem_t;

  expItem_t    expQ[$];
  expItem_t    e;
  logic [31:0] mem [MEMSZ];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int xferCount   = 0;
  int doneCount   = 0;
  int readyMode   = 0;
  int phase       = 0;

  // monitor bookkeeping
  bit          prevValid   = 1'b0;
  bit          prevReady   = 1'b0;
  bit          prevBusy    = 1'b0;
  logic [31:0] prevData;
  logic [6:0]  prevRow;
  logic [6:0]  prevCol;
  logic        prevLast;
  bit          firstPending = 1'b0;
  bit          lastWasLast  = 1'b0;
  int          busyRiseCyc  = 0;
  int          lastXferCyc  = 0;
  int          runXfers     = 0;

  result_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MAX_LEN    (ML),
    .MAX_LEN_LOG(MLL),
    .RES_BASE   (BASE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .result_ready   (result_ready),
    .memory_data_out(memory_data_out),
    .memory_address (memory_address),
    .write_enable   (write_enable),
    .out_data       (out_data),
    .out_row        (out_row),
    .out_col        (out_col),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc             <= cyc + 1;
    memory_data_out <= mem[memory_address];
  end

  // Consumer readiness: 0 = always ready, 1 = pattern 1,0,0, 2 = random
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (phase == 0);
        phase     = (phase + 1) % 3;
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Stream monitor
  always @(negedge clk) begin
    if (reset) begin
      prevValid   = 1'b0;
      prevBusy    = 1'b0;
      lastWasLast = 1'b0;
    end else begin
      if (busy && !prevBusy) begin
        busyRiseCyc  = cyc;
        firstPending = 1'b1;
        runXfers     = 0;
      end
      if (prevValid && !prevReady) begin
        checkOutput("stall_valid", 32'(out_valid), 1);
        if (out_valid) begin
          checkOutput("stall_data", out_data, prevData);
          checkOutput("stall_row", 32'(out_row), 32'(prevRow));
          checkOutput("stall_col", 32'(out_col), 32'(prevCol));
          checkOutput("stall_last", 32'(out_last), 32'(prevLast));
        end
      end
      if (out_valid && firstPending) begin
        checkOutput("first_valid_latency", cyc - busyRiseCyc, 5);
        firstPending = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_transfer", 32'(out_valid), 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("data", out_data, e.data);
          checkOutput("row", 32'(out_row), e.row);
          checkOutput("col", 32'(out_col), e.col);
          checkOutput("last", 32'(out_last), 32'(e.last));
          checkOutput("write_enable", 32'(write_enable), 0);
          if (readyMode == 0 && runXfers > 0)
            checkOutput("back_to_back", cyc - lastXferCyc, 1);
        end
        lastXferCyc = cyc;
        lastWasLast = out_last;
        runXfers++;
        xferCount++;
      end
      if (done) begin
        doneCount++;
        if (lastWasLast) begin
          checkOutput("done_after_last", cyc - lastXferCyc, 1);
          lastWasLast = 1'b0;
        end
      end
      prevValid = out_valid;
      prevReady = out_ready;
      prevData  = out_data;
      prevRow   = out_row;
      prevCol   = out_col;
      prevLast  = out_last;
      prevBusy  = busy;
    end
  end

  // Load header and elements into memory and queue what the stream must show
  task automatic loadMatrix(input int rows, input int cols, input bit queueIt,
                            input bit seqData);
    int       addr;
    expItem_t it;
    mem[BASE % MEMSZ]       = rows;
    mem[(BASE + 1) % MEMSZ] = cols;
    if (queueIt) begin
      for (int i = 0; i < rows; i++) begin
        for (int j = 0; j < cols; j++) begin
          addr      = (BASE + 2 + i * cols + j) % MEMSZ;
          mem[addr] = seqData ? 32'(i * cols + j + 1) : $urandom;
          it.data   = mem[addr];
          it.row    = i;
          it.col    = j;
          it.last   = (i == rows - 1) && (j == cols - 1);
          expQ.push_back(it);
        end
      end
    end
  endtask

  task automatic applyStimulus(input int rows, input int cols, input int mode,
                               input bit expectErr, input int holdCycles,
                               input bit seqData);
    int doneBefore;
    bit gotDone;
    readyMode = mode;
    loadMatrix(rows, cols, !expectErr, seqData);
    doneBefore = doneCount;
    @(posedge clk);
    #1 result_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("busy_after_start", 32'(busy), 1);
    checkOutput("error_cleared", 32'(error), 0);
    gotDone = 1'b0;
    for (int k = 0; k < 3000 && !gotDone; k++) begin
      @(negedge clk);
      if (done) gotDone = 1'b1;
    end
    checkOutput("done_seen", 32'(gotDone), 1);
    repeat (holdCycles) @(negedge clk);
    checkOutput("done_once", doneCount - doneBefore, 1);
    checkOutput("busy_idle", 32'(busy), 0);
    checkOutput("error_flag", 32'(error), 32'(expectErr));
    checkOutput("queue_drained", expQ.size(), 0);
    expQ.delete();
    @(posedge clk);
    #1 result_ready = 1'b0;
    @(posedge clk);
  endtask

  task automatic resetDuringReadout();
    int start;
    bit reached;
    readyMode = 0;
    loadMatrix(3, 3, 1'b1, 1'b0);
    start = xferCount;
    @(posedge clk);
    #1 result_ready = 1'b1;
    reached = 1'b0;
    for (int k = 0; k < 200 && !reached; k++) begin
      @(posedge clk);
      if (xferCount - start >= 2) reached = 1'b1;
    end
    checkOutput("two_transfers_seen", 32'(reached), 1);
    #1 reset = 1'b1;
    expQ.delete();
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_address", 32'(memory_address), 0);
    checkOutput("rst_done", 32'(done), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    result_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("post_rst_no_valid", 32'(out_valid), 0);
    end
    checkOutput("post_rst_busy", 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset        = 1'b1;
    result_ready = 1'b0;
    out_ready    = 1'b1;
    for (int a = 0; a < MEMSZ; a++) mem[a] = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_address", 32'(memory_address), 0);
    checkOutput("reset_valid", 32'(out_valid), 0);
    checkOutput("reset_last", 32'(out_last), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_error", 32'(error), 0);
    checkOutput("reset_data", out_data, 0);
    checkOutput("reset_row", 32'(out_row), 0);
    checkOutput("reset_col", 32'(out_col), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 0);

    $display("[TB] 2x3 sequential data, always ready");
    applyStimulus(2, 3, 0, 1'b0, 3, 1'b1);
    $display("[TB] 2x3 sequential data, ready pattern 1,0,0");
    applyStimulus(2, 3, 1, 1'b0, 3, 1'b1);

    $display("[TB] bad headers");
    applyStimulus(0, 3, 0, 1'b1, 3, 1'b0);
    applyStimulus(3, 101, 0, 1'b1, 3, 1'b0);
    applyStimulus(101, 2, 0, 1'b1, 3, 1'b0);
    applyStimulus(2, 32'h0001_0003, 0, 1'b1, 3, 1'b0);
    applyStimulus(1, 0, 2, 1'b1, 3, 1'b0);

    $display("[TB] 1x1 with address wrap");
    applyStimulus(1, 1, 0, 1'b0, 3, 1'b0);

    $display("[TB] maximum dimension");
    applyStimulus(100, 2, 2, 1'b0, 3, 1'b0);
    applyStimulus(1, 100, 0, 1'b0, 3, 1'b0);

    $display("[TB] result_ready held high");
    applyStimulus(2, 2, 0, 1'b0, 50, 1'b0);
    applyStimulus(2, 2, 2, 1'b0, 3, 1'b0);

    $display("[TB] reset mid-stream");
    resetDuringReadout();
    applyStimulus(3, 3, 0, 1'b0, 3, 1'b1);

    $display("[TB] random readouts");
    for (int n = 0; n < 12; n++) begin
      applyStimulus(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                    int'($urandom_range(0, 2)), 1'b0, 3, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
